// File: rtl/aes_round_sched.sv
// aes_round_sched: control FSM for an iterative AES-128 datapath.
// Sequences initial key add, rounds 1..ROUNDS and result hand-off.
module aes_round_sched #(
    parameter int ROUNDS = 10,
    parameter int RW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_dec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          dp_init,
    output logic          dp_en,
    output logic          dp_last,
    output logic          dp_dec,
    output logic [RW-1:0] rk_idx,
    output logic [RW-1:0] rnd,
    output logic          busy,
    output logic [15:0]   blk_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [RW-1:0] LAST = RW'(ROUNDS);
    localparam logic [RW-1:0] ONE  = RW'(1);

    state_t        state_q, state_d;
    logic [RW-1:0] rnd_q, rnd_d;
    logic          dec_q, dec_d;
    logic [15:0]   blk_cnt_q, blk_cnt_d;

    logic          is_last;

    assign is_last = (rnd_q == LAST);

    // State, round counter, latched mode and completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rnd_q     <= '0;
            dec_q     <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            dec_q     <= dec_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, count rounds in RUN, hand off in DONE.
    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        dec_d     = dec_q;
        blk_cnt_d = blk_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dec_d   = in_dec;
                    rnd_d   = ONE;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (is_last) begin
                    state_d = ST_DONE;
                end else begin
                    rnd_d = rnd_q + ONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d   = ST_IDLE;
                    rnd_d     = '0;
                    blk_cnt_d = blk_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rnd_d   = '0;
            end
        endcase
    end

    // Datapath control decode; the key index runs backwards when decrypting.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dp_init   = 1'b0;
        dp_en     = 1'b0;
        dp_last   = 1'b0;
        busy      = 1'b0;
        rk_idx    = '0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dp_init = 1'b1;
                    rk_idx  = in_dec ? LAST : '0;
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                dp_en   = 1'b1;
                dp_last = is_last;
                rk_idx  = dec_q ? (LAST - rnd_q) : rnd_q;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign rnd     = rnd_q;
    assign dp_dec  = dec_q;
    assign blk_cnt = blk_cnt_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// tb_aes_round_sched: random stimulus against a cycle-level reference
// model; expected round controls are queued and popped by a monitor.
module tb_aes_round_sched;

    localparam int R  = 10;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_dec = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          dp_init;
    logic          dp_en;
    logic          dp_last;
    logic          dp_dec;
    logic [RW-1:0] rk_idx;
    logic [RW-1:0] rnd;
    logic          busy;
    logic [15:0]   blk_cnt;

    aes_round_sched #(.ROUNDS(R), .RW(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dec    (in_dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dp_init   (dp_init),
        .dp_en     (dp_en),
        .dp_last   (dp_last),
        .dp_dec    (dp_dec),
        .rk_idx    (rk_idx),
        .rnd       (rnd),
        .busy      (busy),
        .blk_cnt   (blk_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rk;
        int last;
        int dec;
    } rexp_t;

    rexp_t rq[$];
    int    oq[$];

    int total = 0;
    int bad   = 0;
    int chk_on = 0;

    // model: 0 = idle, 1 = rounds in flight, 2 = waiting for consumer
    int          m_ph   = 0;
    int          m_left = 0;
    int          m_dec  = 0;
    logic [15:0] m_cnt  = 16'd0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one block = init cycle, R round cycles, then hold.
    always @(posedge clk) begin
        if (rst) begin
            m_ph   <= 0;
            m_left <= 0;
            m_dec  <= 0;
            m_cnt  <= 16'd0;
            rq.delete();
            oq.delete();
        end else begin
            case (m_ph)
                0: if (in_valid) begin
                    for (int r = 1; r <= R; r++) begin
                        rexp_t e;
                        e.rk   = in_dec ? (R - r) : r;
                        e.last = (r == R);
                        e.dec  = int'(in_dec);
                        rq.push_back(e);
                    end
                    oq.push_back(int'(in_dec));
                    m_dec  <= int'(in_dec);
                    m_left <= R;
                    m_ph   <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_ph <= 2;
                end
                default: if (out_ready) begin
                    m_cnt <= m_cnt + 16'd1;
                    m_ph  <= 0;
                end
            endcase
        end
    end

    // Monitor: compare DUT against model state and popped expectations.
    always @(negedge clk) begin
        if (!rst && chk_on != 0) begin
            int exp_rnd;
            int exp_init;
            exp_init = (m_ph == 0) && in_valid;
            exp_rnd  = (m_ph == 0) ? 0 : (m_ph == 1) ? (R - m_left + 1) : R;
            chk("in_ready", int'(in_ready), int'(m_ph == 0));
            chk("busy", int'(busy), int'(m_ph != 0));
            chk("out_valid", int'(out_valid), int'(m_ph == 2));
            chk("dp_init", int'(dp_init), exp_init);
            chk("dp_en", int'(dp_en), int'(m_ph == 1));
            chk("rnd", int'(rnd), exp_rnd);
            chk("dp_dec", int'(dp_dec), m_dec);
            chk("blk_cnt", int'(blk_cnt), int'(m_cnt));
            chk("init_en_excl", int'(dp_init & dp_en), 0);
            if (exp_init != 0)
                chk("init_rk", int'(rk_idx), in_dec ? R : 0);
            if (!dp_en) chk("last_wo_en", int'(dp_last), 0);
            if (dp_en) begin
                if (rq.size() == 0) begin
                    chk("round_unexpected", 1, 0);
                end else begin
                    rexp_t e;
                    e = rq.pop_front();
                    chk("round_rk", int'(rk_idx), e.rk);
                    chk("round_last", int'(dp_last), e.last);
                    chk("round_dec", int'(dp_dec), e.dec);
                end
            end
            if (out_valid && out_ready) begin
                if (oq.size() == 0) chk("out_unexpected", 1, 0);
                else chk("out_dec", int'(dp_dec), oq.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic d, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_dec    = d;
        out_ready = r;
    endtask

    task automatic wait_ph(input int p, input int lim);
        int ok;
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            if (m_ph == p) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok == 0) chk("timeout_wait", m_ph, p);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_dp_init"}, int'(dp_init), 0);
        chk({tag, "_dp_en"}, int'(dp_en), 0);
        chk({tag, "_dp_last"}, int'(dp_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_rk_idx"}, int'(rk_idx), 0);
        chk({tag, "_rnd"}, int'(rnd), 0);
        chk({tag, "_dp_dec"}, int'(dp_dec), 0);
        chk({tag, "_blk_cnt"}, int'(blk_cnt), 0);
    endtask

    initial begin
        int found;
        #1 rst = 1'b1;
        #1 chk_reset_vals("por");
        @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1;

        // encrypt, then decrypt, consumer always ready
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        wait_ph(0, 30);
        chk("enc_cnt", int'(blk_cnt), 1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        wait_ph(0, 30);
        chk("dec_cnt", int'(blk_cnt), 2);

        // backpressure with a competing request
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        wait_ph(2, 30);
        for (int i = 0; i < 5; i++) drive(1'b1, i[0], 1'b0);
        chk("bp_held", int'(out_valid), 1);
        drive(1'b0, 1'b0, 1'b1);
        wait_ph(0, 10);
        chk("bp_cnt", int'(blk_cnt), 3);

        // mode input toggles during the run
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) drive(1'b0, ~i[0], 1'b1);
        wait_ph(0, 10);

        // random traffic
        for (int i = 0; i < 800; i++)
            drive(1'($urandom_range(0, 2) != 0), 1'($urandom),
                  1'($urandom_range(0, 3) != 0));
        drive(1'b0, 1'b0, 1'b1);
        wait_ph(0, 40);

        // asynchronous reset in the middle of round 5
        drive(1'b1, 1'($urandom), 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_ph == 1 && (R - m_left + 1) == 5) begin
                found = 1;
                break;
            end
        end
        if (found == 0) chk("timeout_rnd5", 0, 1);
        #2 rst = 1'b1;
        #1 chk_reset_vals("mid");
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        wait_ph(0, 30);
        chk("post_rst_cnt", int'(blk_cnt), 1);

        // completion counter wrap
        drive(1'b0, 1'b0, 1'b1);
        force dut.blk_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(posedge clk);
        #1 release dut.blk_cnt_q;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        wait_ph(0, 30);
        chk("wrap", int'(blk_cnt), 0);

        chk("rq_drained", rq.size(), 0);
        chk("oq_drained", oq.size(), 0);
        drive(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
